// File: rtl/gpio_link_pkg.sv
// Shared types and constants for the GPIO byte-link receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gpio_link_pkg;

    localparam int ADDR_FLAG_BIT = 8;
    localparam int LINK_W        = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_HI,
        S_RD_LO,
        S_INC_HI,
        S_INC_LO,
        S_DECODE,
        S_POLL
    } link_state_e;

    typedef struct packed {
        logic [7:0] port;
        logic [7:0] data;
    } link_event_t;

endpackage

// File: rtl/link_ev_fifo.sv
// Generic first-word-fall-through FIFO with occupancy count.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: push ignored when full, pop ignored when empty.
module link_ev_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem_q[rd_ptr_q];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/gpio_link_rx.sv
// Strobes the GPIO link, decodes tagged words into (port,data) events. Optional GPIO_LINK_RX_STATS_EN adds counters.
// Latency: 17 clk per word at STROBE_CYC=4; ev_valid one cycle after DECODE.
// Backpressure: stalls in RD_LO (before link_incr) while the event FIFO is full.
module gpio_link_rx
    import gpio_link_pkg::*;
#(
    parameter int STROBE_CYC = 4,
    parameter int POLL_CYC   = 64,
    parameter int EV_DEPTH   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LINK_W-1:0] link_word,
    input  logic              link_has_data,
    output logic              link_rdclk,
    output logic              link_incr,
    output logic              ev_valid,
    output logic [7:0]        ev_port,
    output logic [7:0]        ev_data,
    input  logic              ev_ready,
    output logic              err_orphan
`ifdef GPIO_LINK_RX_STATS_EN
    ,
    output logic [15:0]       stat_words,
    output logic [15:0]       stat_events,
    output logic [7:0]        stat_orphans
`endif
);

    localparam int CNT_MAX = (POLL_CYC > STROBE_CYC) ? POLL_CYC : STROBE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] POLL_LAST   = CNT_W'(POLL_CYC - 1);

    link_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LINK_W-1:0] word_s1_q, word_s2_q, word_q;
    logic              hd_s1_q, hd_s2_q, has_q;
    logic              rdclk_q, rdclk_d, incr_q, incr_d;
    logic [7:0]        cur_port_q;
    logic              port_valid_q;
    logic              err_q;
    logic              latch, set_port, push, orphan;

    link_event_t                  push_ev, head_ev;
    logic [$clog2(EV_DEPTH):0]    fifo_count;
    logic                         fifo_full, fifo_empty;

    // Two-flop synchronizer for the asynchronous link inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_s1_q <= '0;
            word_s2_q <= '0;
            hd_s1_q   <= 1'b0;
            hd_s2_q   <= 1'b0;
        end else begin
            word_s1_q <= link_word;
            word_s2_q <= word_s1_q;
            hd_s1_q   <= link_has_data;
            hd_s2_q   <= hd_s1_q;
        end
    end

    // FSM, phase counter, strobes, decode state and the registered orphan pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            rdclk_q      <= 1'b0;
            incr_q       <= 1'b0;
            word_q       <= '0;
            has_q        <= 1'b0;
            cur_port_q   <= '0;
            port_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdclk_q <= rdclk_d;
            incr_q  <= incr_d;
            err_q   <= orphan;
            if (latch) begin
                word_q <= word_s2_q;
                has_q  <= hd_s2_q;
            end
            if (set_port) begin
                cur_port_q   <= word_q[7:0];
                port_valid_q <= 1'b1;
            end
        end
    end

    // Next-state logic; strobes are decoded from the next state so they are glitch-free flops.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        latch    = 1'b0;
        set_port = 1'b0;
        push     = 1'b0;
        orphan   = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_RD_HI;
                cnt_d   = '0;
            end
            S_RD_HI: begin
                if (cnt_q == STROBE_LAST) begin
                    latch   = 1'b1;
                    state_d = S_RD_LO;
                    cnt_d   = '0;
                end
            end
            S_RD_LO: begin
                if (cnt_q == STROBE_LAST) begin
                    cnt_d = cnt_q;
                    if (!has_q) begin
                        state_d = S_POLL;
                        cnt_d   = '0;
                    end else if (!fifo_full) begin
                        state_d = S_INC_HI;
                        cnt_d   = '0;
                    end
                end
            end
            S_INC_HI: begin
                if (cnt_q == STROBE_LAST) begin
                    state_d = S_INC_LO;
                    cnt_d   = '0;
                end
            end
            S_INC_LO: begin
                if (cnt_q == STROBE_LAST) begin
                    state_d = S_DECODE;
                    cnt_d   = '0;
                end
            end
            S_DECODE: begin
                state_d = S_RD_HI;
                cnt_d   = '0;
                if (word_q[ADDR_FLAG_BIT]) begin
                    set_port = 1'b1;
                end else if (port_valid_q) begin
                    push = 1'b1;
                end else begin
                    orphan = 1'b1;
                end
            end
            S_POLL: begin
                if (cnt_q == POLL_LAST) begin
                    state_d = S_RD_HI;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        rdclk_d = (state_d == S_RD_HI);
        incr_d  = (state_d == S_INC_HI);
    end

    assign push_ev.port = cur_port_q;
    assign push_ev.data = word_q[7:0];

    link_ev_fifo #(
        .W     ($bits(link_event_t)),
        .DEPTH (EV_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_ev),
        .pop      (ev_ready),
        .pop_dat  (head_ev),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign link_rdclk = rdclk_q;
    assign link_incr  = incr_q;
    assign err_orphan = err_q;
    assign ev_valid   = (fifo_count != '0);
    // Head is masked while empty so the outputs read zero instead of stale storage.
    assign ev_port    = fifo_empty ? 8'h00 : head_ev.port;
    assign ev_data    = fifo_empty ? 8'h00 : head_ev.data;

`ifdef GPIO_LINK_RX_STATS_EN
    logic [15:0] stat_words_q, stat_events_q;
    logic [7:0]  stat_orph_q;

    // Activity counters: words and events wrap, orphans saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_words_q  <= '0;
            stat_events_q <= '0;
            stat_orph_q   <= '0;
        end else begin
            if (state_q == S_DECODE) stat_words_q <= stat_words_q + 1'b1;
            if (push) stat_events_q <= stat_events_q + 1'b1;
            if (orphan && (stat_orph_q != 8'hFF)) stat_orph_q <= stat_orph_q + 1'b1;
        end
    end

    assign stat_words   = stat_words_q;
    assign stat_events  = stat_events_q;
    assign stat_orphans = stat_orph_q;
`endif

endmodule

// File: doc/gpio_link_rx.md
# gpio_link_rx

Pi-side endpoint of the FPGA→Pi GPIO byte link. It drives the link read strobe and the address-increment strobe, and samples the 9-bit tagged words. Each word is either an address marker (bit 8 = 1) or a data byte (bit 8 = 0). The block decodes the stream into buffered (port, data) write events for downstream sound/IDE emulation logic. It replaces software bit-banging on the second board and serves as the bench-side partner of the ISA bridge.

## Interface
- STROBE_CYC, 4: clk cycles each strobe phase (high or low) is held; min 3.
- POLL_CYC, 64: idle cycles between polls when the link reports empty.
- EV_DEPTH, 8: event FIFO depth; power of 2, ≥2.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- link_word  in  9  {addr_flag, byte} from link (GPIO16, GPIO7..0); asynchronous to clk.
- link_has_data  in  1  link FIFO non-empty indicator (GPIO17); asynchronous.
- link_rdclk  out  1  read strobe (GPIO18); rising edge presents word and refreshes has_data.
- link_incr  out  1  address-increment strobe (GPIO19); rising edge advances link read pointer.
- ev_valid  out  1  event available (FIFO non-empty).
- ev_port  out  8  port low byte of head event (e.g. 8'h88).
- ev_data  out  8  data byte of head event.
- ev_ready  in  1  consumer pop; the head event is popped when ev_valid && ev_ready.
- err_orphan  out  1  one-cycle pulse when a data word arrives with no prior marker.

## Operation
- link_word and link_has_data pass through a 2-flop synchronizer. Sampling occurs only after the inputs have been stable for a full STROBE_CYC phase.
- FSM states:
  - IDLE: go to RD_HI.
  - RD_HI: link_rdclk = 1 for STROBE_CYC cycles. On the last cycle, latch word and has_data.
  - RD_LO: link_rdclk = 0 for STROBE_CYC cycles.
    - If the latched has_data = 0, go to POLL.
    - Otherwise, if the event FIFO is full, stay in RD_LO until it is not full.
    - Otherwise, go to INC_HI.
  - INC_HI / INC_LO: link_incr = 1, then 0, each for STROBE_CYC cycles.
  - DECODE: one cycle, then go to RD_HI.
  - POLL: wait POLL_CYC cycles, then go to RD_HI.
- DECODE rules:
  - word[8] = 1: cur_port ← word[7:0]; port_valid ← 1. No event is produced.
  - word[8] = 0 and port_valid = 1: push {cur_port, word[7:0]}. cur_port is retained, so several data bytes after one marker are all legal.
  - word[8] = 0 and port_valid = 0: drop the word and pulse err_orphan.
- The event FIFO is first-word-fall-through with EV_DEPTH entries. Push happens only in DECODE.
- The full check occurs before link_incr, so no word is ever consumed without buffer space.

## Timing
- Reset values: link_rdclk = 0, link_incr = 0, ev_valid = 0, ev_port = 0, ev_data = 0, err_orphan = 0; FSM = IDLE; port_valid = 0; FIFO empty; counters = 0.
- Per-word link cost with STROBE_CYC = 4 is 17 cycles: RD_HI 4 + RD_LO 4 + INC_HI 4 + INC_LO 4 + DECODE 1.
- Latency: ev_valid rises on the cycle after DECODE for a data word that lands in an empty FIFO.
- err_orphan is asserted in the cycle after DECODE, for exactly 1 cycle.
- Push and pop in the same cycle leave the count unchanged. Pop on an empty FIFO is ignored.
- Strobe edges are always ≥ STROBE_CYC cycles apart, and link_rdclk and link_incr are never high simultaneously.
- Reset mid-transaction: both strobes drop asynchronously, queued events are discarded, and port_valid is cleared.
  - A partially issued link_incr may or may not have advanced the link.
  - Data following reset before a marker is therefore reported as orphan; this is intended.

## Configuration
- GPIO_LINK_RX_STATS_EN, when defined, adds three outputs:
  - stat_words [15:0]: wrapping count of consumed words.
  - stat_events [15:0]: wrapping count of pushed events.
  - stat_orphans [7:0]: saturating count of orphan words, stops at 255.
- The counters reset to 0. When the macro is undefined, these ports and registers do not exist and behaviour is otherwise identical.

## Structure
- Package gpio_link_pkg holds:
  - ADDR_FLAG_BIT = 8 and LINK_W = 9.
  - The FSM state enum.
  - The link_event_t struct {port[7:0], data[7:0]}.
- Sub-module link_ev_fifo: a parameterised FWFT FIFO with count, full and empty outputs; also reusable for the audio path.
- The synchronizer is inline.

## Test plan
- Link model holds [1_88, 0_20, 1_89, 0_A5]. Expect events (88,20) then (89,A5), link_incr pulsed 4 times, err_orphan never asserted.
- After reset, model holds [0_33, 1_70, 0_01, 0_02]. Expect err_orphan for 33, then events (70,01) and (70,02).
- link_has_data = 0: only link_rdclk pulses occur, spaced 2·STROBE_CYC + POLL_CYC apart, and link_incr stays 0.
- ev_ready = 0 with 12 data words after marker 1_71: exactly 8 events are buffered, FSM waits in RD_LO, and link_incr count = 9. Raising ev_ready drains all 12 events in order.
- Assert rst_n low during INC_HI: strobes go 0 in the same cycle without waiting for clk, and ev_valid = 0. Restart with 0_44 → err_orphan.
- With GPIO_LINK_RX_STATS_EN and the first scenario: stat_words = 4, stat_events = 2, stat_orphans = 0.
